alarm_slot_bank: RTL and testbench
==================================

Name: alarm_slot_bank

Overview:
Parametrised successor to the single time-holding register: it stores NUM_SLOTS alarm times (BCD hour/min/sec) with per-slot arm bits. It compares each slot against the running clock time on every seconds tick, and runs a ring/snooze state machine. It sits between the time counter (the source of cur_* and sec_tick) and the display/buzzer logic.

Parameters:
NUM_SLOTS, 4, number of alarm slots (2..16)
SLOT_W, 2, slot index width; must equal clog2(NUM_SLOTS)
SNOOZE_MIN, 5, snooze delay in minutes (integer 1..59)
RING_SECS, 60, sec_tick count before an unattended ring auto-stops (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe for one slot
wr_slot  in  SLOT_W  slot to write
wr_hour, wr_min, wr_sec  in  8 each  BCD time to store
wr_arm  in  1  arm bit to store with the time
wr_err  out  1  one-cycle pulse: write rejected because of invalid BCD
rd_slot  in  SLOT_W  slot to read back
rd_hour, rd_min, rd_sec  out  8 each  registered readback of slot rd_slot
rd_armed  out  1  registered arm bit of slot rd_slot
cur_hour, cur_min, cur_sec  in  8 each  current BCD time
sec_tick  in  1  one-cycle pulse; cur_* holds the new second during this cycle
snooze  in  1  snooze request (level, sampled each cycle)
stop  in  1  stop request (level, sampled each cycle)
ringing  out  1  alarm active
ring_slot  out  SLOT_W  slot that triggered the current or pending ring
alarm_pulse  out  1  one-cycle pulse on every entry into RING

Behaviour:
- Reset (asynchronous, active-high) clears the following:
  - all slots to 00:00:00, disarmed;
  - rd_*, wr_err, ringing, ring_slot and alarm_pulse to 0;
  - the FSM to IDLE;
  - the ring counter and the snooze time register.
- Reset asserted mid-ring or mid-snooze drops ringing on the same clock edge it is applied.
- Write rules:
  - On wr_en, the slot updates at the next posedge.
  - The write is accepted only if each field is valid BCD: hour 00-23, min 00-59, sec 00-59.
  - On an invalid field the slot is unchanged and wr_err=1 for exactly the next cycle.
- Readback has 1-cycle latency: rd_* reflect slot rd_slot as stored at the previous edge. Reading the slot being written in the same cycle returns the old value.
- Match:
  - Evaluated only in cycles with sec_tick=1.
  - A slot matches when it is armed and all three fields equal cur_*.
  - When several slots match, the lowest index wins.
  - The comparison uses stored values from before any same-cycle write.
- FSM states: IDLE, RING, SNOOZE.
- From IDLE:
  - Goes to RING on sec_tick with a match.
  - ring_slot takes the winning index, the ring counter clears, and alarm_pulse=1 for one cycle.
- In RING:
  - ringing=1.
  - The ring counter increments on each sec_tick.
  - stop=1 -> IDLE next edge.
  - snooze=1 (with stop=0) -> SNOOZE next edge, and the snooze time is loaded as cur time + SNOOZE_MIN minutes.
  - Counter reaching RING_SECS -> IDLE.
  - New matches are ignored.
- Snooze-time arithmetic:
  - BCD minute add; if the sum >= 60, subtract 60 and increment the hour.
  - Hour 23 wraps to 00.
  - Seconds are copied from cur_sec.
- In SNOOZE:
  - ringing=0 and ring_slot holds.
  - stop=1 -> IDLE.
  - On sec_tick with cur time equal to the snooze time -> RING: ring counter clears and alarm_pulse=1.
  - Matches on other slots are ignored in SNOOZE.
- Priority within a cycle: reset > stop > snooze > auto-stop > match.
- The stored alarm slots are never modified by snooze. The slot stays armed after stop/auto-stop, so it rings again the next day.
- Writing or disarming the ringing slot during RING/SNOOZE does not end the ring; only stop, auto-stop or reset do.

Test Plan:
- Reset, then write slot 2 = 07:30:00 armed and read slot 2 -> rd_* = 07,30,00 and rd_armed=1 one cycle after rd_slot is applied; all other slots read 00:00:00, disarmed.
- Write 24:00:00 or 12:6A:00 -> wr_err pulses one cycle; slot readback is unchanged.
- Slots 1 and 3 both armed at 06:00:00; drive sec_tick with cur=06:00:00 -> alarm_pulse=1, ringing=1, ring_slot=1. After 60 sec_ticks with no input -> ringing=0, FSM back in IDLE.
- Ringing at 23:58:10 and snooze asserted (SNOOZE_MIN=5) -> ringing=0. At sec_tick with cur=00:03:10 -> ringing=1 and alarm_pulse=1. stop and snooze asserted together -> IDLE, no snooze.
- Assert reset while RING is active -> ringing=0 immediately. Drive a further sec_tick at the matching time -> no ring, because the slots are disarmed.
- Write slot 0 with a new time in the same cycle as a sec_tick matching its old time -> the ring triggers on the old value, and readback shows the new value afterwards.

Source files
------------

// File: rtl/alarm_slot_bank.sv
// Bank of NUM_SLOTS armed BCD alarm times checked against the running clock on each
// seconds tick. A ring/snooze state machine drives the buzzer, with auto-stop.
module alarm_slot_bank #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [7:0]        wr_hour,
  input  logic [7:0]        wr_min,
  input  logic [7:0]        wr_sec,
  input  logic              wr_arm,
  output logic              wr_err,
  input  logic [SLOT_W-1:0] rd_slot,
  output logic [7:0]        rd_hour,
  output logic [7:0]        rd_min,
  output logic [7:0]        rd_sec,
  output logic              rd_armed,
  input  logic [7:0]        cur_hour,
  input  logic [7:0]        cur_min,
  input  logic [7:0]        cur_sec,
  input  logic              sec_tick,
  input  logic              snooze,
  input  logic              stop,
  output logic              ringing,
  output logic [SLOT_W-1:0] ring_slot,
  output logic              alarm_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  localparam logic [7:0] RING_LIMIT = 8'(RING_SECS);

  logic [7:0]           slot_hour_q [NUM_SLOTS];
  logic [7:0]           slot_min_q  [NUM_SLOTS];
  logic [7:0]           slot_sec_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_arm_q;

  logic [7:0]  rd_hour_q, rd_min_q, rd_sec_q;
  logic        rd_armed_q, wr_err_q;
  state_t      state_q, state_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [SLOT_W-1:0] ring_slot_q, ring_slot_d;
  logic        pulse_q, pulse_d;
  logic [7:0]  snz_hour_q, snz_hour_d, snz_min_q, snz_min_d, snz_sec_q, snz_sec_d;

  logic        wr_valid, wr_in_range, rd_in_range;
  logic        match_hit, snz_hit;
  logic [SLOT_W-1:0] match_idx;
  logic [6:0]  cur_min_bin, cur_hour_bin, snz_min_bin, snz_hour_bin;
  logic [7:0]  min_sum;

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign wr_valid = ((wr_hour[7:4] < 4'd2 && wr_hour[3:0] <= 4'd9) ||
                     (wr_hour[7:4] == 4'd2 && wr_hour[3:0] <= 4'd3)) &&
                    (wr_min[7:4] <= 4'd5 && wr_min[3:0] <= 4'd9) &&
                    (wr_sec[7:4] <= 4'd5 && wr_sec[3:0] <= 4'd9);
  assign wr_in_range = int'(wr_slot) < NUM_SLOTS;
  assign rd_in_range = int'(rd_slot) < NUM_SLOTS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_hour_q[i] <= '0;
        slot_min_q[i]  <= '0;
        slot_sec_q[i]  <= '0;
      end
      slot_arm_q <= '0;
    end else if (wr_en && wr_valid && wr_in_range) begin
      slot_hour_q[wr_slot] <= wr_hour;
      slot_min_q[wr_slot]  <= wr_min;
      slot_sec_q[wr_slot]  <= wr_sec;
      slot_arm_q[wr_slot]  <= wr_arm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hour_q  <= '0;
      rd_min_q   <= '0;
      rd_sec_q   <= '0;
      rd_armed_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_hour_q  <= rd_in_range ? slot_hour_q[rd_slot] : 8'h00;
      rd_min_q   <= rd_in_range ? slot_min_q[rd_slot]  : 8'h00;
      rd_sec_q   <= rd_in_range ? slot_sec_q[rd_slot]  : 8'h00;
      rd_armed_q <= rd_in_range ? slot_arm_q[rd_slot]  : 1'b0;
      wr_err_q   <= wr_en && !wr_valid;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_arm_q[i] && slot_hour_q[i] == cur_hour &&
          slot_min_q[i] == cur_min && slot_sec_q[i] == cur_sec) begin
        match_hit = 1'b1;
        match_idx = SLOT_W'(i);
      end
    end
  end

  assign snz_hit = (snz_hour_q == cur_hour) && (snz_min_q == cur_min) && (snz_sec_q == cur_sec);

  always_comb begin
    cur_min_bin  = 7'(cur_min[7:4]) * 7'd10 + 7'(cur_min[3:0]);
    cur_hour_bin = 7'(cur_hour[7:4]) * 7'd10 + 7'(cur_hour[3:0]);
    min_sum      = {1'b0, cur_min_bin} + 8'(SNOOZE_MIN);
    snz_min_bin  = 7'(min_sum);
    snz_hour_bin = cur_hour_bin;
    if (min_sum >= 8'd60) begin
      snz_min_bin  = 7'(min_sum - 8'd60);
      snz_hour_bin = (cur_hour_bin == 7'd23) ? 7'd0 : cur_hour_bin + 7'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    ring_slot_d = ring_slot_q;
    pulse_d     = 1'b0;
    snz_hour_d  = snz_hour_q;
    snz_min_d   = snz_min_q;
    snz_sec_d   = snz_sec_q;
    case (state_q)
      S_IDLE: begin
        if (!stop && sec_tick && match_hit) begin
          state_d     = S_RING;
          ring_slot_d = match_idx;
          ring_cnt_d  = '0;
          pulse_d     = 1'b1;
        end
      end
      S_RING: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (snooze) begin
          state_d    = S_SNOOZE;
          snz_hour_d = bin_to_bcd(snz_hour_bin);
          snz_min_d  = bin_to_bcd(snz_min_bin);
          snz_sec_d  = cur_sec;
        end else if (sec_tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_d == RING_LIMIT) state_d = S_IDLE;
        end
      end
      S_SNOOZE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (sec_tick && snz_hit) begin
          state_d    = S_RING;
          ring_cnt_d = '0;
          pulse_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ring_cnt_q  <= '0;
      ring_slot_q <= '0;
      pulse_q     <= 1'b0;
      snz_hour_q  <= '0;
      snz_min_q   <= '0;
      snz_sec_q   <= '0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      ring_slot_q <= ring_slot_d;
      pulse_q     <= pulse_d;
      snz_hour_q  <= snz_hour_d;
      snz_min_q   <= snz_min_d;
      snz_sec_q   <= snz_sec_d;
    end
  end

  assign wr_err      = wr_err_q;
  assign rd_hour     = rd_hour_q;
  assign rd_min      = rd_min_q;
  assign rd_sec      = rd_sec_q;
  assign rd_armed    = rd_armed_q;
  assign ringing     = (state_q == S_RING);
  assign ring_slot   = ring_slot_q;
  assign alarm_pulse = pulse_q;

endmodule

// File: tb/tb_alarm_slot_bank.sv
// Bench for alarm_slot_bank: write/readback vector table, directed ring/snooze/reset
// sequences, then random traffic against a seconds-of-day reference model.
module tb_alarm_slot_bank;
  localparam int NUM_SLOTS = 4, SLOT_W = 2, SNOOZE_MIN = 5, RING_SECS = 60;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_en = 1'b0, wr_arm = 1'b0, wr_err;
  logic [SLOT_W-1:0] wr_slot = '0, rd_slot = '0, ring_slot;
  logic [7:0] wr_hour = '0, wr_min = '0, wr_sec = '0;
  logic [7:0] rd_hour, rd_min, rd_sec;
  logic rd_armed;
  logic [7:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic sec_tick = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic ringing, alarm_pulse;

  alarm_slot_bank #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .SNOOZE_MIN(SNOOZE_MIN),
                    .RING_SECS(RING_SECS)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_slot(wr_slot), .wr_hour(wr_hour),
    .wr_min(wr_min), .wr_sec(wr_sec), .wr_arm(wr_arm), .wr_err(wr_err), .rd_slot(rd_slot),
    .rd_hour(rd_hour), .rd_min(rd_min), .rd_sec(rd_sec), .rd_armed(rd_armed),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec), .sec_tick(sec_tick),
    .snooze(snooze), .stop(stop), .ringing(ringing), .ring_slot(ring_slot),
    .alarm_pulse(alarm_pulse));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  // Reference model: slot times as plain integers, snooze target as seconds of day.
  int m_h [NUM_SLOTS], m_m [NUM_SLOTS], m_s [NUM_SLOTS];
  bit m_arm [NUM_SLOTS];
  int m_mode, m_slot, m_cnt, m_snz;
  int e_rdh, e_rdm, e_rds;
  bit e_rda, e_err, e_pulse;

  typedef struct {
    logic we; logic [1:0] ws; logic [7:0] h, m, s; logic arm; logic [1:0] rs;
    logic x_err; logic [7:0] x_h, x_m, x_s; logic x_arm;
  } vec_t;
  vec_t vecs [14];

  logic [7:0] pool_h [5] = '{8'h06, 8'h06, 8'h06, 8'h23, 8'h00};
  logic [7:0] pool_m [5] = '{8'h00, 8'h05, 8'h10, 8'h58, 8'h03};
  logic [7:0] pool_s [5] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h10};

  function automatic int bcd_val(input logic [7:0] b);
    if (b[3:0] > 4'd9 || b[7:4] > 4'd9) return -1;
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int maxv);
    int v;
    v = bcd_val(b);
    return v >= 0 && v <= maxv;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m_h[i] = 0; m_m[i] = 0; m_s[i] = 0; m_arm[i] = 1'b0;
    end
    m_mode = 0; m_slot = 0; m_cnt = 0; m_snz = 0;
  endtask

  task automatic model_step();
    int ct, idx;
    bit hit, ok;
    ct = bcd_val(cur_hour) * 3600 + bcd_val(cur_min) * 60 + bcd_val(cur_sec);
    e_rdh = m_h[rd_slot]; e_rdm = m_m[rd_slot]; e_rds = m_s[rd_slot]; e_rda = m_arm[rd_slot];
    ok = field_ok(wr_hour, 23) && field_ok(wr_min, 59) && field_ok(wr_sec, 59);
    e_err = wr_en && !ok;
    hit = 1'b0; idx = 0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (!hit && m_arm[i] && (m_h[i] * 3600 + m_m[i] * 60 + m_s[i]) == ct) begin
        hit = 1'b1; idx = i;
      end
    e_pulse = 1'b0;
    case (m_mode)
      0: if (!stop && sec_tick && hit) begin
           m_mode = 1; m_slot = idx; m_cnt = 0; e_pulse = 1'b1;
         end
      1: if (stop) m_mode = 0;
         else if (snooze) begin
           m_mode = 2; m_snz = (ct + SNOOZE_MIN * 60) % 86400;
         end else if (sec_tick) begin
           m_cnt++;
           if (m_cnt == RING_SECS) m_mode = 0;
         end
      default: if (stop) m_mode = 0;
         else if (sec_tick && ct == m_snz) begin
           m_mode = 1; m_cnt = 0; e_pulse = 1'b1;
         end
    endcase
    if (wr_en && ok) begin
      m_h[wr_slot] = bcd_val(wr_hour); m_m[wr_slot] = bcd_val(wr_min);
      m_s[wr_slot] = bcd_val(wr_sec); m_arm[wr_slot] = wr_arm;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [1:0] sl, input logic [7:0] h, m, s, input logic arm);
    wr_slot = sl; wr_hour = h; wr_min = m; wr_sec = s; wr_arm = arm; wr_en = 1'b1;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic tick(input logic [7:0] h, m, s);
    cur_hour = h; cur_min = m; cur_sec = s; sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
  endtask

  initial begin
    int p;
    model_reset();
    vecs[0]  = '{1'b1, 2'd2, 8'h07, 8'h30, 8'h00, 1'b1, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 8'h07, 8'h30, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 2'd2, 8'h24, 8'h00, 8'h00, 1'b0, 2'd2, 1'b1, 8'h07, 8'h30, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 8'h07, 8'h30, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 2'd2, 8'h12, 8'h6A, 8'h00, 1'b1, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 8'h07, 8'h30, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 2'd2, 8'h12, 8'h60, 8'h00, 1'b1, 2'd2, 1'b1, 8'h07, 8'h30, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 2'd1, 8'h23, 8'h59, 8'h59, 1'b0, 2'd1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 8'h23, 8'h59, 8'h59, 1'b0};
    vecs[11] = '{1'b1, 2'd3, 8'h00, 8'h00, 8'h60, 1'b1, 2'd1, 1'b1, 8'h23, 8'h59, 8'h59, 1'b0};
    vecs[12] = '{1'b1, 2'd0, 8'h1A, 8'h00, 8'h00, 1'b1, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset rd_hour", rd_hour, 8'h00);
    chk("reset rd_min", rd_min, 8'h00);
    chk("reset rd_sec", rd_sec, 8'h00);
    chk("reset rd_armed", rd_armed, 1'b0);
    chk("reset wr_err", wr_err, 1'b0);
    chk("reset ringing", ringing, 1'b0);
    chk("reset ring_slot", ring_slot, 2'd0);
    chk("reset alarm_pulse", alarm_pulse, 1'b0);

    foreach (vecs[i]) begin
      wr_en = vecs[i].we; wr_slot = vecs[i].ws; wr_hour = vecs[i].h; wr_min = vecs[i].m;
      wr_sec = vecs[i].s; wr_arm = vecs[i].arm; rd_slot = vecs[i].rs;
      cycle();
      chk($sformatf("vec%0d wr_err", i), wr_err, vecs[i].x_err);
      chk($sformatf("vec%0d rd_hour", i), rd_hour, vecs[i].x_h);
      chk($sformatf("vec%0d rd_min", i), rd_min, vecs[i].x_m);
      chk($sformatf("vec%0d rd_sec", i), rd_sec, vecs[i].x_s);
      chk($sformatf("vec%0d rd_armed", i), rd_armed, vecs[i].x_arm);
    end
    idle_inputs();

    // Two armed slots at the same time, then unattended auto-stop.
    do_reset();
    wr(2'd1, 8'h06, 8'h00, 8'h00, 1'b1);
    wr(2'd3, 8'h06, 8'h00, 8'h00, 1'b1);
    tick(8'h06, 8'h00, 8'h00);
    chk("match pulse", alarm_pulse, 1'b1);
    chk("match ringing", ringing, 1'b1);
    chk("match lowest slot", ring_slot, 2'd1);
    cycle();
    chk("pulse one cycle", alarm_pulse, 1'b0);
    chk("still ringing", ringing, 1'b1);
    for (int i = 0; i < RING_SECS - 1; i++) begin
      tick(8'h12, 8'h00, 8'h00);
      cycle();
    end
    chk("ring before limit", ringing, 1'b1);
    tick(8'h12, 8'h00, 8'h00);
    chk("auto stop", ringing, 1'b0);
    tick(8'h06, 8'h00, 8'h00);
    chk("rearm after auto stop", ringing, 1'b1);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop", ringing, 1'b0);

    // Snooze across midnight, then stop beating snooze.
    wr(2'd0, 8'h23, 8'h58, 8'h10, 1'b1);
    tick(8'h23, 8'h58, 8'h10);
    chk("late ring", ringing, 1'b1);
    chk("late ring slot", ring_slot, 2'd0);
    snooze = 1'b1;
    cycle();
    snooze = 1'b0;
    chk("snooze quiet", ringing, 1'b0);
    tick(8'h06, 8'h00, 8'h00);
    chk("snooze ignores match", ringing, 1'b0);
    chk("snooze slot holds", ring_slot, 2'd0);
    tick(8'h00, 8'h03, 8'h09);
    chk("snooze early", ringing, 1'b0);
    tick(8'h00, 8'h03, 8'h10);
    chk("snooze wake ringing", ringing, 1'b1);
    chk("snooze wake pulse", alarm_pulse, 1'b1);
    stop = 1'b1; snooze = 1'b1;
    cycle();
    stop = 1'b0; snooze = 1'b0;
    chk("stop over snooze", ringing, 1'b0);
    tick(8'h00, 8'h08, 8'h10);
    chk("no snooze after stop", ringing, 1'b0);

    // Asynchronous reset while ringing.
    tick(8'h06, 8'h00, 8'h00);
    chk("ring before reset", ringing, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async reset ringing", ringing, 1'b0);
    chk("async reset pulse", alarm_pulse, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick(8'h06, 8'h00, 8'h00);
    chk("no ring after reset", ringing, 1'b0);

    // Same-cycle write and matching tick: old value rings, new value reads back.
    wr(2'd0, 8'h08, 8'h00, 8'h00, 1'b1);
    wr_en = 1'b1; wr_slot = 2'd0; wr_hour = 8'h09; wr_min = 8'h00; wr_sec = 8'h00; wr_arm = 1'b1;
    rd_slot = 2'd0; cur_hour = 8'h08; cur_min = 8'h00; cur_sec = 8'h00; sec_tick = 1'b1;
    cycle();
    idle_inputs();
    chk("old value rings", ringing, 1'b1);
    chk("old value pulse", alarm_pulse, 1'b1);
    chk("same cycle read old", rd_hour, 8'h08);
    cycle();
    chk("read new value", rd_hour, 8'h09);

    // Random traffic against the reference model.
    do_reset();
    idle_inputs();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        continue;
      end
      wr_en = ($urandom_range(0, 7) == 0);
      wr_slot = SLOT_W'($urandom_range(0, NUM_SLOTS - 1));
      if ($urandom_range(0, 3) == 0) begin
        wr_hour = 8'($urandom); wr_min = 8'($urandom); wr_sec = 8'($urandom);
      end else begin
        p = $urandom_range(0, 3);
        wr_hour = pool_h[p]; wr_min = pool_m[p]; wr_sec = pool_s[p];
      end
      wr_arm = ($urandom_range(0, 3) != 0);
      rd_slot = SLOT_W'($urandom_range(0, NUM_SLOTS - 1));
      p = $urandom_range(0, 4);
      cur_hour = pool_h[p]; cur_min = pool_m[p]; cur_sec = pool_s[p];
      sec_tick = ($urandom_range(0, 1) == 1);
      snooze = ($urandom_range(0, 149) == 0);
      stop = ($urandom_range(0, 149) == 0);
      cycle();
      chk("rnd rd_hour", rd_hour, to_bcd(e_rdh));
      chk("rnd rd_min", rd_min, to_bcd(e_rdm));
      chk("rnd rd_sec", rd_sec, to_bcd(e_rds));
      chk("rnd rd_armed", rd_armed, e_rda);
      chk("rnd wr_err", wr_err, e_err);
      chk("rnd ringing", ringing, m_mode == 1);
      chk("rnd ring_slot", ring_slot, m_slot);
      chk("rnd alarm_pulse", alarm_pulse, e_pulse);
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
